// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared state encodings and hold/bubble patterns for the pipeline stall controller.
// Pure definitions: no latency, no backpressure.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_BUSY = 2'd1,
    ST_MEM_WAIT = 2'd2
  } ctrl_state_e;

  localparam int HOLD_PC     = 0;
  localparam int HOLD_IFID   = 1;
  localparam int HOLD_IDEXE  = 2;
  localparam int HOLD_EXEMEM = 3;

  localparam int BUBBLE_IDEXE  = 0;
  localparam int BUBBLE_EXEMEM = 1;
  localparam int BUBBLE_MEMWB  = 2;

  localparam logic [3:0] HOLD_NONE  = 4'b0000;
  localparam logic [3:0] HOLD_LDUSE = 4'b0011;
  localparam logic [3:0] HOLD_DIV   = 4'b0111;
  localparam logic [3:0] HOLD_ALL   = 4'b1111;

  localparam logic [2:0] BUBBLE_NONE  = 3'b000;
  localparam logic [2:0] BUBBLE_LDUSE = 3'b001;
  localparam logic [2:0] BUBBLE_DIV   = 3'b010;
  localparam logic [2:0] BUBBLE_MEM   = 3'b100;

  // True when ID reads register wa; r0 is hardwired zero and never hazards.
  function automatic logic src_match(input logic rreg1, input logic [4:0] ra1,
                                     input logic rreg2, input logic [4:0] ra2,
                                     input logic [4:0] wa);
    return (wa != 5'd0) && ((rreg1 && (ra1 == wa)) || (rreg2 && (ra2 == wa)));
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_hazard_cmp.sv
// Load-use detector: ID sources vs. load destinations in EXE and MEM.
// Latency 0 (pure combinational); no backpressure.
module stall_hazard_cmp
  import pipe_stall_ctrl_pkg::*;
(
  input  logic       id_rreg1,
  input  logic [4:0] id_ra1,
  input  logic       id_rreg2,
  input  logic [4:0] id_ra2,
  input  logic       exe_mreg,
  input  logic [4:0] exe_wa,
  input  logic       mem_mreg,
  input  logic [4:0] mem_wa,
  output logic       ld_use
);

  assign ld_use = (exe_mreg && src_match(id_rreg1, id_ra1, id_rreg2, id_ra2, exe_wa)) ||
                  (mem_mreg && src_match(id_rreg1, id_ra1, id_rreg2, id_ra2, mem_wa));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard scheduler: freezes stages / injects bubbles for load-use, DIV and memory waits.
// Outputs are 0-latency from registered state + inputs; MEM wait pre-empts DIV, which pre-empts load-use.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES  = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       cpu_clk_50M,
  input  logic       cpu_rst,
  input  logic       id_rreg1,
  input  logic [4:0] id_ra1,
  input  logic       id_rreg2,
  input  logic [4:0] id_ra2,
  input  logic       exe_mreg,
  input  logic [4:0] exe_wa,
  input  logic       mem_mreg,
  input  logic [4:0] mem_wa,
  input  logic       exe_div,
  input  logic       mem_req,
  input  logic       dmem_ack,
  output logic [3:0] hold,
  output logic [2:0] bubble,
  output logic       div_done,
  output logic       mem_err,
  output logic [1:0] ctrl_state
);

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_save_q, div_save_d;
  logic             ret_div_q, ret_div_d;
  logic             div_seen_q;
  logic             ld_use;
  logic             mem_stall;
  logic [3:0]       hold_c;
  logic [2:0]       bubble_c;
  logic             done_c;
  logic             err_c;

  stall_hazard_cmp u_hazard_cmp (
    .id_rreg1 (id_rreg1),
    .id_ra1   (id_ra1),
    .id_rreg2 (id_rreg2),
    .id_ra2   (id_ra2),
    .exe_mreg (exe_mreg),
    .exe_wa   (exe_wa),
    .mem_mreg (mem_mreg),
    .mem_wa   (mem_wa),
    .ld_use   (ld_use)
  );

  assign mem_stall = mem_req && !dmem_ack;

  always_comb begin
    hold_c     = HOLD_NONE;
    bubble_c   = BUBBLE_NONE;
    done_c     = 1'b0;
    err_c      = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_save_d = div_save_q;
    ret_div_d  = ret_div_q;
    case (state_q)
      ST_DIV_BUSY: begin
        if (mem_stall) begin
          // Park the divider count; it resumes untouched once memory releases.
          hold_c     = HOLD_ALL;
          bubble_c   = BUBBLE_MEM;
          state_d    = ST_MEM_WAIT;
          cnt_d      = MEM_LOAD;
          div_save_d = cnt_q;
          ret_div_d  = 1'b1;
        end else if (cnt_q == '0) begin
          done_c  = 1'b1;
          state_d = ST_RUN;
        end else begin
          hold_c   = HOLD_DIV;
          bubble_c = BUBBLE_DIV;
          cnt_d    = cnt_q - 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ack || (cnt_q == '0)) begin
          err_c     = !dmem_ack;
          state_d   = ret_div_q ? ST_DIV_BUSY : ST_RUN;
          cnt_d     = ret_div_q ? div_save_q : '0;
          ret_div_d = 1'b0;
        end else begin
          hold_c   = HOLD_ALL;
          bubble_c = BUBBLE_MEM;
          cnt_d    = cnt_q - 1'b1;
        end
      end
      default: begin
        // RUN, and the unused encoding which behaves as RUN for one cycle.
        if (mem_stall) begin
          hold_c    = HOLD_ALL;
          bubble_c  = BUBBLE_MEM;
          state_d   = ST_MEM_WAIT;
          cnt_d     = MEM_LOAD;
          ret_div_d = 1'b0;
        end else if (exe_div && !div_seen_q) begin
          hold_c   = HOLD_DIV;
          bubble_c = BUBBLE_DIV;
          state_d  = ST_DIV_BUSY;
          cnt_d    = DIV_LOAD;
        end else if (ld_use) begin
          hold_c   = HOLD_LDUSE;
          bubble_c = BUBBLE_LDUSE;
        end
        if (state_q != ST_RUN) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      div_save_q <= '0;
      ret_div_q  <= 1'b0;
      div_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_save_q <= div_save_d;
      ret_div_q  <= ret_div_d;
      // The finished DIV may still be flagged in EXE for a cycle; ignore it until EXE moves on.
      if (done_c)
        div_seen_q <= 1'b1;
      else if (!hold_c[HOLD_IDEXE])
        div_seen_q <= 1'b0;
    end
  end

  assign hold       = cpu_rst ? HOLD_NONE : hold_c;
  assign bubble     = cpu_rst ? BUBBLE_NONE : bubble_c;
  assign div_done   = done_c && !cpu_rst;
  assign mem_err    = err_c && !cpu_rst;
  assign ctrl_state = state_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with hand-computed expectations.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       cpu_rst = 1'b1;
  logic       id_rreg1 = 1'b0, id_rreg2 = 1'b0;
  logic [4:0] id_ra1 = '0, id_ra2 = '0;
  logic       exe_mreg = 1'b0, mem_mreg = 1'b0;
  logic [4:0] exe_wa = '0, mem_wa = '0;
  logic       exe_div = 1'b0, mem_req = 1'b0, dmem_ack = 1'b0;
  logic [3:0] hold;
  logic [2:0] bubble;
  logic       div_done, mem_err;
  logic [1:0] ctrl_state;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.DIV_CYCLES(32), .MEM_TIMEOUT(255), .CNT_W(8)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (cpu_rst),
    .id_rreg1    (id_rreg1),
    .id_ra1      (id_ra1),
    .id_rreg2    (id_rreg2),
    .id_ra2      (id_ra2),
    .exe_mreg    (exe_mreg),
    .exe_wa      (exe_wa),
    .mem_mreg    (mem_mreg),
    .mem_wa      (mem_wa),
    .exe_div     (exe_div),
    .mem_req     (mem_req),
    .dmem_ack    (dmem_ack),
    .hold        (hold),
    .bubble      (bubble),
    .div_done    (div_done),
    .mem_err     (mem_err),
    .ctrl_state  (ctrl_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int done_at, stall_n, err_n, err_at;
  logic [3:0] h_save;

  initial begin
    // Reset, with a live load-use hazard presented: outputs must stay 0.
    tick();
    exe_mreg = 1'b1; exe_wa = 5'd2; id_rreg1 = 1'b1; id_ra1 = 5'd2; exe_div = 1'b1;
    #1;
    chk("rst_hold", hold, 4'b0000);
    chk("rst_bubble", bubble, 3'b000);
    chk("rst_state", ctrl_state, 2'd0);
    chk("rst_pulses", {div_done, mem_err}, 2'b00);
    exe_div = 1'b0;
    tick(); cpu_rst = 1'b0; exe_mreg = 1'b0;
    #1;
    chk("idle_hold", hold, 4'b0000);

    // lw $2 in EXE, ID reads $2: two bubble cycles as the load walks EXE -> MEM.
    tick(); exe_mreg = 1'b1; exe_wa = 5'd2; #1;
    chk("ldu_exe", {hold, bubble}, {4'b0011, 3'b001});
    tick(); exe_mreg = 1'b0; mem_mreg = 1'b1; mem_wa = 5'd2; #1;
    chk("ldu_mem", {hold, bubble}, {4'b0011, 3'b001});
    tick(); mem_mreg = 1'b0; #1;
    chk("ldu_clear", {hold, bubble}, 7'd0);
    // r0 never hazards; disabled read port never hazards; source 2 does.
    tick(); exe_mreg = 1'b1; exe_wa = 5'd0; id_ra1 = 5'd0; #1;
    chk("ldu_r0", {hold, bubble}, 7'd0);
    tick(); exe_wa = 5'd2; id_ra1 = 5'd2; id_rreg1 = 1'b0; #1;
    chk("ldu_noread", {hold, bubble}, 7'd0);
    tick(); id_rreg2 = 1'b1; id_ra2 = 5'd2; #1;
    chk("ldu_src2", {hold, bubble}, {4'b0011, 3'b001});
    tick(); exe_mreg = 1'b0; id_rreg2 = 1'b0; #1;

    // Plain DIV: 31 stall cycles, done on cycle 32, then the stale exe_div is ignored.
    done_at = 0; stall_n = 0; h_save = 4'hf;
    for (int c = 1; c <= 33; c++) begin
      tick(); exe_div = 1'b1; #1;
      if (div_done && done_at == 0) done_at = c;
      if (hold == 4'b0111 && bubble == 3'b010) stall_n++;
      if (c == 2) chk("div_state", ctrl_state, 2'd1);
      if (c == 33) h_save = hold;
    end
    chk("div_done_cycle", done_at, 32);
    chk("div_stall_cycles", stall_n, 31);
    chk("div_seen_ignore", h_save, 4'b0000);
    chk("div_back_run", ctrl_state, 2'd0);
    tick(); exe_div = 1'b0; #1;

    // Memory access acked after 3 wait cycles.
    for (int c = 1; c <= 5; c++) begin
      tick(); mem_req = (c <= 4); dmem_ack = (c == 4); #1;
      if (c <= 3) chk("memw_stall", {hold, bubble}, {4'b1111, 3'b100});
      if (c == 4) chk("memw_release", {hold, bubble, mem_err, ctrl_state}, {7'd0, 1'b0, 2'd2});
      if (c == 5) chk("memw_run", ctrl_state, 2'd0);
    end
    dmem_ack = 1'b0;

    // Memory never acks: one mem_err pulse after 255 cycles in MEM_WAIT (cycle 256 here).
    err_n = 0; err_at = 0; h_save = 4'hf;
    for (int c = 1; c <= 257; c++) begin
      tick(); mem_req = (c <= 256); #1;
      if (mem_err) begin err_n++; err_at = c; h_save = hold; end
    end
    chk("memto_count", err_n, 1);
    chk("memto_cycle", err_at, 256);
    chk("memto_release", h_save, 4'b0000);
    chk("memto_run", {ctrl_state, hold}, {2'd0, 4'b0000});

    // DIV interrupted by a memory wait at its cycle 10 for 4 cycles: done moves to 36.
    tick(); #1;
    done_at = 0;
    for (int c = 1; c <= 38; c++) begin
      tick();
      exe_div = (c <= 36); mem_req = (c >= 10 && c <= 13); dmem_ack = (c == 13);
      #1;
      if (div_done && done_at == 0) done_at = c;
      if (c == 10) chk("divmem_stall", {hold, bubble}, {4'b1111, 3'b100});
      if (c == 13) chk("divmem_release", {hold, ctrl_state}, {4'b0000, 2'd2});
      if (c == 14) chk("divmem_resume", {hold, bubble, ctrl_state}, {4'b0111, 3'b010, 2'd1});
    end
    chk("divmem_done_cycle", done_at, 36);
    mem_req = 1'b0; dmem_ack = 1'b0; exe_div = 1'b0;
    tick(); #1;

    // Reset in the middle of a DIV.
    for (int c = 1; c <= 5; c++) begin
      tick(); exe_div = 1'b1; cpu_rst = (c == 5); #1;
      if (c == 5) chk("rstdiv_outputs", {hold, bubble, div_done, mem_err}, 9'd0);
    end
    tick(); cpu_rst = 1'b0; exe_div = 1'b0; #1;
    chk("rstdiv_run", {ctrl_state, hold, div_done}, {2'd0, 4'b0000, 1'b0});
    done_at = 0;
    for (int c = 1; c <= 35; c++) begin
      tick(); #1;
      if (div_done || mem_err) done_at++;
    end
    chk("rstdiv_no_pulse", done_at, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
